// File: rtl/serial_bit_streamer.sv
// serial_bit_streamer: serializes WIDTH-bit words onto x through a one-word holding buffer for gapless streaming.
module serial_bit_streamer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             word_done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic S_IDLE  = 1'b0;
  localparam logic S_SHIFT = 1'b1;
  logic             r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_hold;
  logic [CW-1:0]    r_cnt;
  logic             r_hold_full;
  logic             w_acc;
  logic             w_last;
  logic [WIDTH-1:0] w_shifted;
  assign din_ready = ~r_hold_full & ~rst;
  assign w_acc     = din_valid & din_ready;
  assign w_last    = (r_state == S_SHIFT) && (r_cnt == CW'(WIDTH - 1));
  assign w_shifted = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
  assign x         = (r_state == S_SHIFT) ? (MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0]) : IDLE_BIT;
  assign x_valid   = r_state == S_SHIFT;
  assign busy      = r_state == S_SHIFT;
  assign word_done = w_last;
  // The last-bit edge either chains the buffered/incoming word or drops back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_hold      <= '0;
      r_cnt       <= '0;
      r_hold_full <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_acc) begin
        r_shift <= din;
        r_cnt   <= '0;
        r_state <= S_SHIFT;
      end
    end else if (w_last) begin
      r_cnt <= '0;
      if (r_hold_full) begin
        r_shift     <= r_hold;
        r_hold_full <= 1'b0;
      end else if (w_acc) begin
        r_shift <= din;
      end else begin
        r_shift <= '0;
        r_state <= S_IDLE;
      end
    end else begin
      r_shift <= w_shifted;
      r_cnt   <= r_cnt + 1'b1;
      if (w_acc) begin
        r_hold      <= din;
        r_hold_full <= 1'b1;
      end
    end
  end
endmodule
